fir_frame_scheduler: RTL
========================

// Module: fir_frame_scheduler
// PURPOSE
//  Shares one FIR filter core (8-bit signed in, 12-bit signed out, clock-enabled delay line) between NCH sample sources.
//  Grants one source per frame (round-robin), streams FRAME_LEN samples into the core, then flushes the delay line with
//  TAPS-1 zero samples so the next source starts from a clean state. Returns the full convolution tagged with source id.
//  Sits between the per-channel sample sources and the shared fir_filter instance.
// PARAMETERS
//  NCH        4   number of requesting channels (>=2); CHW = $clog2(NCH)
//  TAPS       4   FIR tap count (>=2); flush length = TAPS-1
//  FRAME_LEN  4   samples accepted per grant (>=1)
//  FIR_LAT    1   clocks from a fir_ce=1 cycle to the matching fir_y value (>=1)
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-high; clears all state
//  req_valid  in   NCH      per-channel sample valid
//  req_data   in   NCH*8    per-channel signed sample, channel i at [8*i+7:8*i]
//  req_ready  out  NCH      one-hot accept; transfer on req_valid[i]&req_ready[i]
//  fir_ce     out  1        FIR clock enable: delay line shifts in fir_x on this edge
//  fir_x      out  8        signed sample to FIR core
//  fir_y      in   12       signed FIR output
//  out_valid  out  1        one-cycle strobe per FIR output word
//  out_data   out  12       signed filtered value
//  out_ch     out  CHW      channel id that produced out_data
//  out_last   out  1        high with final word (last flush output) of a frame
//  busy       out  1        high in STREAM or FLUSH
// BEHAVIOUR
//  Interface: one clock clk; reset is asynchronous and active-high.
//  Reset: state=IDLE, rr pointer=NCH-1, req_ready=0, fir_ce=0, fir_x=0, out_valid=0, out_data=0, out_ch=0,
//   out_last=0, busy=0, all counters/tag pipeline cleared. Reset mid-frame abandons frame; no out_last issued.
//  States:
//   IDLE: if any req_valid, grant first requesting channel searching upward from rr_ptr+1 (mod NCH);
//    register grant, rr_ptr<=grant, go STREAM. No requests -> stay. req_ready=0 in IDLE.
//   STREAM: req_ready[grant]=1 only. On transfer: fir_ce=1, fir_x=req_data[grant] (combinational), sample_cnt++.
//    Granted req_valid low -> fir_ce=0, fir_x=0, delay line untouched (stall, no limit). Other channels ignored.
//    On transfer with sample_cnt==FRAME_LEN-1 -> FLUSH, sample_cnt<=0.
//   FLUSH: req_ready=0; fir_ce=1, fir_x=0 for exactly TAPS-1 consecutive cycles (flush_cnt);
//    final flush cycle -> IDLE. Min frame period = 1 + FRAME_LEN + TAPS-1 cycles.
//  Tag pipeline: FIR_LAT-stage shift register advancing every clock carrying {ce, ch, last};
//   last=1 only on the final flush cycle. When tag at stage FIR_LAT has ce=1, register
//   out_data<=fir_y, out_ch<=ch, out_last<=last, out_valid<=1; else out_valid<=0, out_data/out_ch/out_last hold
//   (out_last cleared to 0 when out_valid=0).
//  Latency: ce cycle t -> out_valid high in cycle t+FIR_LAT+1. Words per frame = FRAME_LEN+TAPS-1, in order.
//  No output backpressure: every ce cycle yields exactly one out_valid strobe.
//  Tags in flight when next frame starts are unaffected; consecutive frames may overlap on output side.
//  busy: 1 in STREAM/FLUSH, 0 in IDLE (registered with state).
//  No arithmetic on data; widths pass through unchanged.
// TESTING
//  Bench models FIR core: TAPS=4 coeffs all 1, ce-gated delay line, registered y (FIR_LAT=1).
//  T1 reset: assert reset mid-STREAM -> all outputs 0 immediately; after release, IDLE, no out_valid until new grant.
//  T2 single frame: ch0 sends 10,20,30,40 back-to-back -> out_data 10,30,60,100,90,70,40, out_ch=0,
//   out_last only on 40, first out_valid 2 cycles after first accept.
//  T3 round-robin: ch0..ch3 all valid continuously -> grants 0,1,2,3,0; each frame 7 words with matching out_ch.
//  T4 stall: ch2 drops req_valid 3 cycles after 2nd sample -> fir_ce=0 those cycles, outputs identical to T2 values.
//  T5 isolation: ch1 frame 100,100,100,100 then ch3 frame 1,2,3,4 -> ch3 outputs 1,3,6,10,9,7,4 (no ch1 residue).
//  T6 pointer: only ch3 requests, then ch1 and ch3 together -> ch1 granted next (search wraps from 0 after 3).

Source files
------------

// File: rtl/fir_frame_scheduler.sv
// Round-robin frame scheduler for a shared FIR core: streams one channel's frame, flushes the
// delay line with zeros, and tags every FIR output word with the channel that produced it.
module fir_frame_scheduler #(
   parameter int NCH       = 4,
   parameter int TAPS      = 4,
   parameter int FRAME_LEN = 4,
   parameter int FIR_LAT   = 1,
   localparam int CHW      = $clog2(NCH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NCH-1:0]     req_valid,
   input  logic [NCH*8-1:0]   req_data,
   output logic [NCH-1:0]     req_ready,
   output logic               fir_ce,
   output logic [7:0]         fir_x,
   input  logic [11:0]        fir_y,
   output logic               out_valid,
   output logic [11:0]        out_data,
   output logic [CHW-1:0]     out_ch,
   output logic               out_last,
   output logic               busy
);

   localparam int SCW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int FCW  = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
   localparam int TAGW = CHW + 2;
   localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(FRAME_LEN - 1);
   localparam logic [FCW-1:0] FLUSH_LAST  = FCW'(TAPS - 2);
   localparam logic [CHW-1:0] CH_LAST     = CHW'(NCH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CHW-1:0]    rr_ptr_reg, rr_ptr_next;
   logic [CHW-1:0]    grant_reg, grant_next;
   logic [SCW-1:0]    sample_cnt_reg, sample_cnt_next;
   logic [FCW-1:0]    flush_cnt_reg, flush_cnt_next;

   logic [7:0]        chan_data [NCH];
   logic              arb_found;
   logic [CHW-1:0]    arb_grant;
   logic              xfer;
   logic              flush_last;
   logic [TAGW-1:0]   tag_head;
   logic [TAGW-1:0]   tag_tail;

   logic              out_valid_reg;
   logic [11:0]       out_data_reg;
   logic [CHW-1:0]    out_ch_reg;
   logic              out_last_reg;

   genvar gi;

   generate
      for (gi = 0; gi < NCH; gi++) begin : g_unpack
         assign chan_data[gi] = req_data[8*gi +: 8];
      end
   endgenerate

   assign xfer       = (state_reg == STREAM) && req_valid[grant_reg];
   assign flush_last = (state_reg == FLUSH) && (flush_cnt_reg == FLUSH_LAST);

   // Round-robin search: first requester strictly after rr_ptr, wrapping through rr_ptr itself last.
   always_comb begin
      int             idx;
      logic [CHW-1:0] idx_c;
      arb_found = 1'b0;
      arb_grant = '0;
      idx       = 0;
      idx_c     = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx   = (int'(rr_ptr_reg) + k) % NCH;
         idx_c = CHW'(idx);
         if (!arb_found && req_valid[idx_c]) begin
            arb_found = 1'b1;
            arb_grant = idx_c;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         rr_ptr_reg     <= CH_LAST;
         grant_reg      <= '0;
         sample_cnt_reg <= '0;
         flush_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         rr_ptr_reg     <= rr_ptr_next;
         grant_reg      <= grant_next;
         sample_cnt_reg <= sample_cnt_next;
         flush_cnt_reg  <= flush_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      rr_ptr_next     = rr_ptr_reg;
      grant_next      = grant_reg;
      sample_cnt_next = sample_cnt_reg;
      flush_cnt_next  = flush_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (arb_found) begin
               grant_next      = arb_grant;
               rr_ptr_next     = arb_grant;
               sample_cnt_next = '0;
               state_next      = STREAM;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (sample_cnt_reg == SAMPLE_LAST) begin
                  sample_cnt_next = '0;
                  flush_cnt_next  = '0;
                  state_next      = FLUSH;
               end else begin
                  sample_cnt_next = sample_cnt_reg + SCW'(1);
               end
            end
         end
         FLUSH: begin
            if (flush_last) begin
               flush_cnt_next = '0;
               state_next     = IDLE;
            end else begin
               flush_cnt_next = flush_cnt_reg + FCW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A stalled source leaves the delay line untouched; flush cycles always shift in zeros.
   always_comb begin
      req_ready = '0;
      fir_ce    = 1'b0;
      fir_x     = '0;
      case (state_reg)
         STREAM: begin
            req_ready[grant_reg] = 1'b1;
            if (xfer) begin
               fir_ce = 1'b1;
               fir_x  = chan_data[grant_reg];
            end
         end
         FLUSH: fir_ce = 1'b1;
         default: ;
      endcase
   end

   assign busy     = (state_reg != IDLE);
   assign tag_head = {fir_ce, grant_reg, flush_last};

   // Tag pipeline matches the FIR core latency so each fir_y word meets its own {ce, ch, last}.
   generate
      for (gi = 0; gi < FIR_LAT; gi++) begin : g_tag
         logic [TAGW-1:0] tag_reg;
         logic [TAGW-1:0] tag_in;
         if (gi == 0) begin : g_first
            assign tag_in = tag_head;
         end else begin : g_rest
            assign tag_in = g_tag[gi-1].tag_reg;
         end
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               tag_reg <= '0;
            end else begin
               tag_reg <= tag_in;
            end
         end
      end
   endgenerate

   assign tag_tail = g_tag[FIR_LAT-1].tag_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         out_last_reg  <= 1'b0;
      end else if (tag_tail[TAGW-1]) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= fir_y;
         out_ch_reg    <= tag_tail[CHW:1];
         out_last_reg  <= tag_tail[0];
      end else begin
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;
   assign out_last  = out_last_reg;

endmodule
